skew_meas_unit: RTL and testbench
=================================

// Module: skew_meas_unit
// PURPOSE
//  Measures the skew between a periodic reference pulse (sig_i) and a second comparator channel.
//  The strobe generator locks to the sig_i period and fires stb_o on the clock edge that launches each predicted sig_i edge.
//  stb_o goes to an external delay line programmed by delay_code_o; the delayed strobe drives a latch on channel 2, whose output is cmp_out_i.
//  A 10-bit successive-approximation controller converges delay_code_o to floor(skew/step).
// PARAMETERS
//  T_CNT_WIDTH  32  period counter / stb_period_o width
//  CODE_WIDTH   10  delay_code_o width
//  STB_LEN      8   stb_o high time, clk cycles
//  SYNC_STAGES  2   synchronizer depth on sig_i and cmp_out_i
// PORTS
//  clk_i         in   1   single clock; all logic on rising edge
//  rst_i         in   1   synchronous reset, active-high
//  sig_i         in   1   async reference pulse train (channel 1 comparator)
//  cmp_out_i     in   1   async latched channel-2 value (latch holds while delayed stb is high)
//  run_i         in   1   level; rising into IDLE while locked starts a measurement
//  stb_o         out  1   registered strobe to delay line
//  debug_stb_o   out  1   1-cycle pulse at every predicted sig_i edge once locked
//  stb_period_o  out  T_CNT_WIDTH  locked sig_i period in clk cycles
//  delay_code_o  out  CODE_WIDTH   trial/final delay code
//  rdy_o         out  1   measurement done; delay_code_o valid
//  err_o         out  1   sticky error
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs to initial state, err cleared.
//  sig_i and cmp_out_i each pass a SYNC_STAGES flop synchronizer; a rising edge is detected on synced sig_i.
//  Lock FSM:
//   - ACQ0: wait for an edge.
//   - ACQ1: count cycles to the next edge, giving P.
//   - VERIFY: count to the next edge.
//     - Count == P -> LOCKED, stb_period_o = P.
//     - Otherwise reload P and stay in VERIFY; this is not an error.
//  LOCKED:
//   - A free-running phase counter with period P is aligned so phase 0 is the clk edge at which sig_i's edge is launched.
//   - This compensates synchronizer and edge-detect latency.
//   - debug_stb_o pulses at phase 0.
//   - A synced edge arriving at any phase other than the expected one sets err_o.
//   - So does no edge within P cycles of the expected one.
//  Errors (err_o sticky until rst_i):
//   - Counter saturation at 2^T_CNT_WIDTH-1 without an edge.
//   - P < STB_LEN+SYNC_STAGES+4 once locked.
//   - Phase slip while LOCKED.
//   - On error the ctl FSM goes to ERR: rdy_o = 0, stb_o = 0.
//  Strobe: on an internal request, stb_o rises at the next phase 0 and stays high exactly STB_LEN cycles.
//  Controller FSM: IDLE -> ARM -> WAIT -> SAMPLE -> (ARM | DONE); ERR.
//   - IDLE: rdy_o = 0. When run_i = 1 and locked, go to ARM with bit = CODE_WIDTH-1.
//     - delay_code_o = result | (1<<bit), result = 0.
//     - run_i high before lock simply waits.
//   - ARM: request a strobe.
//   - WAIT: until the last cycle of stb_o high.
//   - SAMPLE: read synced cmp_out_i.
//     - 0 (delay shorter than skew): keep the bit in result.
//     - 1: clear it.
//     - If bit == 0, go to DONE; otherwise bit--, present the next trial code, go to ARM.
//  delay_code_o changes only right after SAMPLE, at least P-STB_LEN cycles before the next strobe.
//  One SAR step per sig_i period; DONE is reached within CODE_WIDTH+2 periods of start.
//  DONE: delay_code_o = result (largest code with sample 0), rdy_o = 1, held.
//   - Leaves to IDLE only when run_i = 0; re-measure needs a new run_i rise.
//  rst_i mid-measurement aborts immediately; relock is required.
//  All-ones sample sequence gives code 0; all-zeros gives 2^CODE_WIDTH-1.
// TESTING
//  1. Bench: sig_i = 1-cycle pulse every 21 cycles.
//     -> stb_period_o = 21, debug_stb_o every 21 cycles aligned to sig_i launch, err_o = 0.
//  2. Bench: delay = code*10ps; latch model on channel 2; skew 90ps; run_i = 1.
//     -> rdy_o, delay_code_o = 9 (abs error <= 10ps).
//  3. 100 random skews 1ps..9.999ns, each with reset, lock and run.
//     -> |code*10ps - skew| <= 10ps, err_o never set.
//  4. sig_i period changed 21 -> 25 after lock -> err_o = 1, rdy_o stays 0.
//  5. sig_i held low after reset -> no lock, no stb_o; run_i = 1 gives rdy_o = 0.
//  6. rst_i pulsed mid-search -> outputs 0 next cycle; relock and re-measure give the correct code.

Source files
------------

// File: rtl/skew_meas_unit.sv
// Skew measurement unit: locks a phase counter to the sig_i period, fires a strobe at each
// predicted sig_i launch edge, and runs a successive-approximation search on the delay code.
module skew_meas_unit #(
  parameter int T_CNT_WIDTH = 32,
  parameter int CODE_WIDTH  = 10,
  parameter int STB_LEN     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sig_i,
  input  logic                   cmp_out_i,
  input  logic                   run_i,
  output logic                   stb_o,
  output logic                   debug_stb_o,
  output logic [T_CNT_WIDTH-1:0] stb_period_o,
  output logic [CODE_WIDTH-1:0]  delay_code_o,
  output logic                   rdy_o,
  output logic                   err_o
);

  localparam int SW = $clog2(STB_LEN + 1);
  localparam int BW = (CODE_WIDTH > 1) ? $clog2(CODE_WIDTH) : 1;

  localparam logic [T_CNT_WIDTH-1:0] ONE     = T_CNT_WIDTH'(1);
  localparam logic [T_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [T_CNT_WIDTH-1:0] MIN_P   = T_CNT_WIDTH'(STB_LEN + SYNC_STAGES + 4);
  // A launch at phase 0 shows up as a detected rise while the phase counter reads SYNC_STAGES.
  localparam logic [T_CNT_WIDTH-1:0] EXP_PH  = T_CNT_WIDTH'(SYNC_STAGES);
  localparam logic [T_CNT_WIDTH-1:0] LOCK_PH = T_CNT_WIDTH'(SYNC_STAGES + 1);
  localparam logic [SW-1:0]          STB_LAST_CNT = SW'(STB_LEN - 1);

  typedef enum logic [1:0] {
    L_ACQ0,
    L_ACQ1,
    L_VERIFY,
    L_LOCKED
  } lock_state_t;

  typedef enum logic [2:0] {
    C_IDLE,
    C_ARM,
    C_WAIT,
    C_SAMPLE,
    C_DONE,
    C_ERR
  } ctl_state_t;

  // ---------------------------------------------------------------- synchronizers
  logic [SYNC_STAGES-1:0] sig_sync_q;
  logic [SYNC_STAGES-1:0] cmp_sync_q;
  logic                   sig_prev_q;
  logic                   rise;
  logic                   cmp_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_sync_q <= '0;
      cmp_sync_q <= '0;
      sig_prev_q <= 1'b0;
    end else begin
      sig_sync_q <= {sig_sync_q[SYNC_STAGES-2:0], sig_i};
      cmp_sync_q <= {cmp_sync_q[SYNC_STAGES-2:0], cmp_out_i};
      sig_prev_q <= sig_sync_q[SYNC_STAGES-1];
    end
  end

  assign rise  = sig_sync_q[SYNC_STAGES-1] & ~sig_prev_q;
  assign cmp_s = cmp_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------- lock FSM
  lock_state_t            lock_q, lock_d;
  logic [T_CNT_WIDTH-1:0] cnt_q;
  logic [T_CNT_WIDTH-1:0] per_q;
  logic [T_CNT_WIDTH-1:0] ph_q;
  logic [T_CNT_WIDTH-1:0] per_out_q;
  logic                   dbg_q;
  logic                   err_q;
  logic                   err_set;
  logic                   locked;
  logic                   counting;
  logic                   lock_entry;
  logic                   ph_wrap;

  always_ff @(posedge clk_i) begin
    if (rst_i) lock_q <= L_ACQ0;
    else       lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      L_ACQ0:   if (rise) lock_d = L_ACQ1;
      L_ACQ1:   if (rise) lock_d = L_VERIFY;
      L_VERIFY: if (rise && (cnt_q == per_q)) lock_d = L_LOCKED;
      default:  lock_d = L_LOCKED;
    endcase
  end

  always_comb begin
    locked     = (lock_q == L_LOCKED) && !err_q;
    counting   = (lock_q == L_ACQ1) || (lock_q == L_VERIFY);
    lock_entry = (lock_q == L_VERIFY) && (lock_d == L_LOCKED);
  end

  assign ph_wrap = (ph_q == per_q - ONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      per_q     <= '0;
      ph_q      <= '0;
      per_out_q <= '0;
      dbg_q     <= 1'b0;
    end else begin
      dbg_q <= 1'b0;
      if (lock_q == L_LOCKED) begin
        ph_q  <= ph_wrap ? '0 : ph_q + ONE;
        dbg_q <= ph_wrap && !err_q;
      end else if (lock_entry) begin
        // The edge just detected was launched SYNC_STAGES+1 edges ago.
        ph_q      <= LOCK_PH;
        per_out_q <= cnt_q;
      end else if (rise) begin
        per_q <= cnt_q;
        cnt_q <= ONE;
      end else if (counting && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + ONE;
      end
    end
  end

  // Saturation, too-short period at lock, or any edge off the expected phase (or missing).
  always_comb begin
    err_set = 1'b0;
    if (counting && !rise && (cnt_q == CNT_MAX)) err_set = 1'b1;
    if (lock_entry && (cnt_q < MIN_P))           err_set = 1'b1;
    if ((lock_q == L_LOCKED) && (rise != (ph_q == EXP_PH))) err_set = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_q | err_set;
  end

  // ---------------------------------------------------------------- strobe generator
  logic          stb_q;
  logic          stb_req_q;
  logic [SW-1:0] stb_cnt_q;
  logic          stb_start;
  logic          stb_last;
  logic          arm;

  assign stb_start = stb_req_q && locked && ph_wrap;
  assign stb_last  = stb_q && (stb_cnt_q == STB_LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (rst_i || err_q) begin
      stb_q     <= 1'b0;
      stb_req_q <= 1'b0;
      stb_cnt_q <= '0;
    end else begin
      if (arm) stb_req_q <= 1'b1;
      if (stb_start) begin
        stb_q     <= 1'b1;
        stb_cnt_q <= '0;
        stb_req_q <= 1'b0;
      end else if (stb_q) begin
        if (stb_last) stb_q <= 1'b0;
        else          stb_cnt_q <= stb_cnt_q + SW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- SAR controller FSM
  ctl_state_t            ctl_q, ctl_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [CODE_WIDTH-1:0] bit_mask;
  logic                  sample;
  logic                  start;
  logic                  rdy;

  always_ff @(posedge clk_i) begin
    if (rst_i) ctl_q <= C_IDLE;
    else       ctl_q <= ctl_d;
  end

  always_comb begin
    ctl_d = ctl_q;
    if (err_q) begin
      ctl_d = C_ERR;
    end else begin
      case (ctl_q)
        C_IDLE:   if (run_i && locked) ctl_d = C_ARM;
        C_ARM:    ctl_d = C_WAIT;
        C_WAIT:   if (stb_last) ctl_d = C_SAMPLE;
        C_SAMPLE: ctl_d = (bit_q == '0) ? C_DONE : C_ARM;
        C_DONE:   if (!run_i) ctl_d = C_IDLE;
        default:  ctl_d = C_ERR;
      endcase
    end
  end

  always_comb begin
    arm    = (ctl_q == C_ARM);
    sample = (ctl_q == C_SAMPLE);
    start  = (ctl_q == C_IDLE) && (ctl_d == C_ARM);
    rdy    = (ctl_q == C_DONE);
  end

  // A sample of 1 means the trial delay overshot the skew, so the trial bit is dropped.
  always_comb begin
    bit_mask = CODE_WIDTH'(1) << bit_q;
    code_d   = code_q;
    bit_d    = bit_q;
    if (start) begin
      code_d = CODE_WIDTH'(1) << (CODE_WIDTH - 1);
      bit_d  = BW'(CODE_WIDTH - 1);
    end else if (sample) begin
      if (cmp_s) code_d = code_d & ~bit_mask;
      code_d = code_d | (bit_mask >> 1);
      if (bit_q != '0) bit_d = bit_q - BW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      code_q <= '0;
      bit_q  <= '0;
    end else begin
      code_q <= code_d;
      bit_q  <= bit_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign stb_o        = stb_q;
  assign debug_stb_o  = dbg_q;
  assign stb_period_o = per_out_q;
  assign delay_code_o = code_q;
  assign rdy_o        = rdy;
  assign err_o        = err_q;

endmodule

// File: tb/tb_skew_meas_unit.sv
// Directed + randomized bench for skew_meas_unit with a pulse-train source and a
// delay-line/latch model on channel 2 (step 10 ps per code).
`timescale 1ns/1ps
module tb_skew_meas_unit;
  localparam int TW   = 32;
  localparam int CW   = 10;
  localparam int STEP = 10;

  // ---------------------------------------------------------------- clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic run_i = 1'b0;
  logic sig_i = 1'b0;
  logic cmp_out_i = 1'b0;
  logic          stb_o;
  logic          debug_stb_o;
  logic [TW-1:0] stb_period_o;
  logic [CW-1:0] delay_code_o;
  logic          rdy_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  skew_meas_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sig_i        (sig_i),
    .cmp_out_i    (cmp_out_i),
    .run_i        (run_i),
    .stb_o        (stb_o),
    .debug_stb_o  (debug_stb_o),
    .stb_period_o (stb_period_o),
    .delay_code_o (delay_code_o),
    .rdy_o        (rdy_o),
    .err_o        (err_o)
  );

  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] exp_q[$];

  // ---------------------------------------------------------------- environment models
  int sig_period = 21;
  bit sig_en     = 1'b0;
  int sig_cnt    = 0;
  int skew_ps    = 0;

  // Reference pulse: one clk wide, launched by a rising clk edge.
  always @(posedge clk_i) begin
    #1;
    if (sig_en) begin
      sig_i   = (sig_cnt == 0);
      sig_cnt = (sig_cnt >= sig_period - 1) ? 0 : sig_cnt + 1;
    end else begin
      sig_i   = 1'b0;
      sig_cnt = 0;
    end
  end

  // Delay line + latch: channel 2 is seen high once the delayed strobe lags it by more than the skew.
  always @(posedge stb_o) begin
    int trial;
    trial = int'(delay_code_o);
    #2;
    cmp_out_i = (trial * STEP > skew_ps);
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    run_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (stb_period_o == '0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " period"}, stb_period_o, sig_period);
  endtask

  task automatic measure(input int skew, input string tag);
    int cyc_cnt;
    int exp_code;
    int diff;
    skew_ps  = skew;
    exp_code = skew / STEP;
    if (exp_code > (1 << CW) - 1) exp_code = (1 << CW) - 1;
    exp_q.push_back(CW'(exp_code));
    @(negedge clk_i);
    run_i   = 1'b1;
    cyc_cnt = 0;
    while (rdy_o !== 1'b1 && err_o !== 1'b1 && cyc_cnt < 400) begin
      @(negedge clk_i);
      cyc_cnt++;
    end
    check({tag, " rdy"}, rdy_o, 1'b1);
    check({tag, " latency_ok"}, (cyc_cnt <= (CW + 2) * sig_period), 1'b1);
    check({tag, " code"}, delay_code_o, exp_q.pop_front());
    check({tag, " err"}, err_o, 1'b0);
    if (skew < (1 << CW) * STEP) begin
      diff = int'(delay_code_o) * STEP - skew;
      if (diff < 0) diff = -diff;
      check({tag, " abs_err_ok"}, (diff <= STEP), 1'b1);
    end
    repeat (5) @(negedge clk_i);
    check({tag, " rdy_held"}, rdy_o, 1'b1);
    run_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check({tag, " rdy_clear"}, rdy_o, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stb"},    stb_o,        1'b0);
    check({tag, " dbg"},    debug_stb_o,  1'b0);
    check({tag, " period"}, stb_period_o, 0);
    check({tag, " code"},   delay_code_o, 0);
    check({tag, " rdy"},    rdy_o,        1'b0);
    check({tag, " err"},    err_o,        1'b0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int stb_hi;
    int rdy_hi;
    int dbg_hi;
    int sig_hi;
    int mism;
    int n;

    // Reset state
    do_reset();
    check_all_zero("reset");

    // No reference pulses: never locks, never strobes
    run_i  = 1'b1;
    stb_hi = 0;
    rdy_hi = 0;
    dbg_hi = 0;
    repeat (300) begin
      @(negedge clk_i);
      stb_hi += int'(stb_o);
      rdy_hi += int'(rdy_o);
      dbg_hi += int'(debug_stb_o);
    end
    check("nolock stb_count", stb_hi, 0);
    check("nolock rdy_count", rdy_hi, 0);
    check("nolock dbg_count", dbg_hi, 0);
    check("nolock period", stb_period_o, 0);
    check("nolock err", err_o, 1'b0);
    run_i = 1'b0;

    // Lock on a 21-cycle pulse train; debug pulse must coincide with each sig_i pulse
    sig_period = 21;
    sig_en     = 1'b1;
    do_reset();
    wait_lock("lock21");
    mism   = 0;
    dbg_hi = 0;
    sig_hi = 0;
    repeat (5 * 21) begin
      @(negedge clk_i);
      if (debug_stb_o !== sig_i) mism++;
      dbg_hi += int'(debug_stb_o);
      sig_hi += int'(sig_i);
    end
    check("lock21 dbg_mismatch", mism, 0);
    check("lock21 dbg_count", dbg_hi, 5);
    check("lock21 sig_count", sig_hi, 5);
    check("lock21 err", err_o, 1'b0);

    // Directed skews, including the all-ones and all-zeros sample sequences
    measure(90, "skew90");
    measure(0, "skew0");
    measure(20000, "skew_max");
    measure(10, "skew10");

    // Randomized skews, each with fresh reset and lock
    for (int i = 0; i < 100; i++) begin
      do_reset();
      wait_lock("rand");
      measure(int'($urandom_range(9999, 1)), "rand");
    end

    // Period change after lock must be flagged and stop the search
    do_reset();
    wait_lock("slip");
    skew_ps = 500;
    run_i   = 1'b1;
    repeat (40) @(negedge clk_i);
    sig_period = 25;
    n = 0;
    while (err_o !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("slip err", err_o, 1'b1);
    rdy_hi = 0;
    stb_hi = 0;
    repeat (3) @(negedge clk_i);
    repeat (100) begin
      @(negedge clk_i);
      rdy_hi += int'(rdy_o);
      stb_hi += int'(stb_o);
    end
    check("slip rdy_count", rdy_hi, 0);
    check("slip stb_count", stb_hi, 0);
    check("slip err_sticky", err_o, 1'b1);
    run_i      = 1'b0;
    sig_period = 21;

    // Reset mid-search, then relock and re-measure
    do_reset();
    wait_lock("midrst");
    skew_ps = 4370;
    run_i   = 1'b1;
    repeat (80) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_all_zero("midrst");
    rst_i = 1'b0;
    run_i = 1'b0;
    wait_lock("relock");
    measure(4370, "remeasure");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
